// File: rtl/dds_pkg.sv
// dds_pkg: shared state encoding, default parameters and Nyquist clamp helper for the DDS phase controller
package dds_pkg;
  typedef enum logic [1:0] {IDLE, MULT, WAIT_WRAP} ctrl_state_t;
  localparam int DDS_ADDR_W  = 11;
  localparam int DDS_PHASE_W = 32;
  localparam int DDS_STEP_K  = 179;
  localparam int DDS_WRAP_TO = 65535;
  function automatic logic [63:0] dds_nyq(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction
endpackage

// File: rtl/dds_serial_mult.sv
// dds_serial_mult: LSB-first shift-add code x K multiplier, restartable on start, saturated to Nyquist
module dds_serial_mult
  import dds_pkg::*;
#(
  parameter int          AW = DDS_ADDR_W,
  parameter int          PW = DDS_PHASE_W,
  parameter int unsigned K  = DDS_STEP_K
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start_i,
  input  logic [AW-1:0] a_i,
  output logic          done_o,
  output logic [PW-1:0] p_o
);
  localparam int PRW = AW + PW;
  localparam int CW = (AW > 1) ? $clog2(AW) : 1;
  localparam logic [PRW-1:0] NYQ = PRW'(dds_nyq(PW));
  logic [AW-1:0] code_q, code_d;
  logic [PRW-1:0] mc_q, mc_d, acc_q, acc_d, sum;
  logic [CW-1:0] cnt_q, cnt_d;
  logic run_q, run_d, last;
  // done and p_o reflect the final partial sum combinationally so the caller sees it on the last bit's edge
  always_comb begin
    sum = acc_q + (code_q[0] ? mc_q : '0);
    last = cnt_q == CW'(AW - 1);
    done_o = run_q && !start_i && last;
    p_o = (sum > NYQ) ? NYQ[PW-1:0] : sum[PW-1:0];
    code_d = start_i ? a_i : run_q ? code_q >> 1 : code_q;
    mc_d = start_i ? PRW'(K) : run_q ? mc_q << 1 : mc_q;
    acc_d = start_i ? '0 : run_q ? sum : acc_q;
    cnt_d = start_i ? '0 : run_q ? cnt_q + 1'b1 : cnt_q;
    run_d = start_i || (run_q && !last);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_q <= '0;
      mc_q <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      code_q <= code_d;
      mc_q <= mc_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end
endmodule

// File: rtl/dds_phase_ctrl.sv
// dds_phase_ctrl: converts rotary codes to tuning words and applies them only at a phase wrap
// (or after a timeout), while owning the phase accumulator driving the sine LUT.
module dds_phase_ctrl
  import dds_pkg::*;
#(
  parameter int ADDR_W  = DDS_ADDR_W,
  parameter int PHASE_W = DDS_PHASE_W,
  parameter int STEP_K  = DDS_STEP_K,
  parameter int WRAP_TO = DDS_WRAP_TO
) (
  input  logic               Fg_CLK,
  input  logic               RESETn,
  input  logic [ADDR_W-1:0]  Address,
  input  logic               FreqChng,
  input  logic               Enable,
  output logic [PHASE_W-1:0] Phase,
  output logic [PHASE_W-1:0] TuneWord,
  output logic               Busy,
  output logic               Applied,
  output logic               Forced
);
  localparam int TW = (WRAP_TO > 1) ? $clog2(WRAP_TO) : 1;
  ctrl_state_t state_q, state_d;
  logic [PHASE_W-1:0] phase_q, phase_d, tune_q, tune_d, word_q, word_d, mult_p;
  logic [PHASE_W:0] sum_w;
  logic [TW-1:0] to_q, to_d;
  logic wrap, apply, forced, mult_done, busy_q, applied_q, forced_q;
  dds_serial_mult #(.AW(ADDR_W), .PW(PHASE_W), .K(STEP_K)) u_mult (
    .clk(Fg_CLK),
    .rst_n(RESETn),
    .start_i(FreqChng),
    .a_i(Address),
    .done_o(mult_done),
    .p_o(mult_p)
  );
  // an apply and a new strobe on the same edge both take effect: old word goes out, new code restarts MULT
  always_comb begin
    sum_w = {1'b0, phase_q} + {1'b0, tune_q};
    wrap = sum_w[PHASE_W];
    apply = state_q == WAIT_WRAP && (!Enable || wrap || to_q == TW'(WRAP_TO - 1));
    forced = apply && Enable && !wrap;
    tune_d = apply ? word_q : tune_q;
    word_d = (!FreqChng && state_q == MULT && mult_done) ? mult_p : word_q;
    state_d = FreqChng ? MULT : (state_q == MULT && mult_done) ? WAIT_WRAP : apply ? IDLE : state_q;
    to_d = (state_q == WAIT_WRAP && state_d == WAIT_WRAP) ? to_q + 1'b1 : '0;
    phase_d = Enable ? sum_w[PHASE_W-1:0] : '0;
  end
  always_ff @(posedge Fg_CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q <= IDLE;
      phase_q <= '0;
      tune_q <= '0;
      word_q <= '0;
      to_q <= '0;
      busy_q <= 1'b0;
      applied_q <= 1'b0;
      forced_q <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      tune_q <= tune_d;
      word_q <= word_d;
      to_q <= to_d;
      busy_q <= state_d != IDLE;
      applied_q <= apply;
      forced_q <= forced;
    end
  end
  assign Phase = phase_q;
  assign TuneWord = tune_q;
  assign Busy = busy_q;
  assign Applied = applied_q;
  assign Forced = forced_q;
endmodule

// File: tb/tb_dds_phase_ctrl.sv
// tb_dds_phase_ctrl: randomized scoreboard bench; a request-level reference model predicts each apply
module tb_dds_phase_ctrl;
  localparam int AW = 11;
  localparam int PW = 16;
  localparam int K = 256;
  localparam int TO = 100;
  localparam int NYQ = (1 << (PW - 1)) - 1;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic fc = 1'b0;
  logic en = 1'b1;
  logic [AW-1:0] addr = '0;
  logic [PW-1:0] phase, tune;
  logic busy, applied, forced;
  dds_phase_ctrl #(.ADDR_W(AW), .PHASE_W(PW), .STEP_K(K), .WRAP_TO(TO)) dut (
    .Fg_CLK(clk),
    .RESETn(rst_n),
    .Address(addr),
    .FreqChng(fc),
    .Enable(en),
    .Phase(phase),
    .TuneWord(tune),
    .Busy(busy),
    .Applied(applied),
    .Forced(forced)
  );
  always #5 clk = ~clk;
  typedef struct {
    int cyc;
    int word;
    bit forced;
  } exp_t;
  exp_t q[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int m_phase = 0;
  int m_word = 0;
  int m_nw = 0;
  int m_ready = 0;
  int n_forced = 0;
  bit m_pend = 1'b0;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask
  function automatic int sat(input int a);
    return (a * K > NYQ) ? NYQ : a * K;
  endfunction
  // reference: a pending request becomes eligible 12 edges after its strobe, then applies on the
  // first edge with Enable low, a carry out of phase+word, or the timeout count reached
  always @(posedge clk) begin : model
    bit ap, fo, wr;
    cyc++;
    if (!rst_n) begin
      m_phase = 0;
      m_word = 0;
      m_pend = 1'b0;
    end else begin
      ap = 1'b0;
      fo = 1'b0;
      wr = m_phase + m_word > (1 << PW) - 1;
      if (m_pend && cyc >= m_ready) begin
        fo = en && !wr && (cyc - m_ready == TO - 1);
        ap = !en || wr || fo;
      end
      m_phase = en ? (m_phase + m_word) % (1 << PW) : 0;
      if (ap) begin
        q.push_back('{cyc, m_nw, fo});
        m_word = m_nw;
        m_pend = 1'b0;
      end
      if (fc) begin
        m_pend = 1'b1;
        m_nw = sat(int'(addr));
        m_ready = cyc + AW + 1;
      end
    end
  end
  always @(negedge clk) begin : monitor
    exp_t e;
    chk("phase", int'(phase), m_phase);
    chk("tuneword", int'(tune), m_word);
    chk("busy", int'(busy), int'(m_pend));
    if (applied) begin
      if (q.size() == 0) chk("unexpected_apply", int'(applied), 0);
      else begin
        e = q.pop_front();
        chk("apply_cycle", cyc, e.cyc);
        chk("apply_word", int'(tune), e.word);
        chk("apply_forced", int'(forced), int'(e.forced));
        if (forced) n_forced++;
      end
    end else begin
      chk("forced_without_apply", int'(forced), 0);
      if (q.size() != 0 && q[0].cyc <= cyc) begin
        chk("missed_apply", int'(applied), 1);
        void'(q.pop_front());
      end
    end
  end
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic strobe(input int a);
    addr = AW'(a);
    fc = 1'b1;
    @(negedge clk);
    fc = 1'b0;
  endtask
  initial begin
    tick(3);
    chk("rst_phase", int'(phase), 0);
    chk("rst_tune", int'(tune), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_applied", int'(applied), 0);
    rst_n = 1'b1;
    tick(200);
    strobe(1);
    tick(130);
    chk("timeout_forced_seen", n_forced, 1);
    chk("timeout_word", int'(tune), K);
    strobe(4);
    tick(130);
    strobe(4);
    tick(100);
    chk("wrap_word", int'(tune), 1024);
    strobe(4);
    tick(4);
    strobe(8);
    tick(130);
    chk("restart_word", int'(tune), 2048);
    strobe(2047);
    tick(130);
    chk("sat_word", int'(tune), NYQ);
    en = 1'b0;
    strobe(37);
    tick(20);
    chk("disabled_phase", int'(phase), 0);
    chk("disabled_word", int'(tune), sat(37));
    en = 1'b1;
    strobe(0);
    tick(130);
    chk("zero_word", int'(tune), 0);
    repeat (40) begin
      if ($urandom_range(0, 7) == 0) en = ~en;
      strobe(int'($urandom_range(0, 2047)));
      tick(int'($urandom_range(0, 130)));
    end
    en = 1'b1;
    tick(130);
    strobe(300);
    tick(11);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_phase", int'(phase), 0);
    chk("mid_rst_tune", int'(tune), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_applied", int'(applied), 0);
    chk("mid_rst_forced", int'(forced), 0);
    tick(3);
    rst_n = 1'b1;
    tick(150);
    chk("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
